serial_tx: RTL
==============

// Module: serial_tx
//
// PURPOSE
//   UART transmitter that drains a show-ahead synchronous FIFO read port.
//   Pops one byte at a time and shifts it out LSB-first as 8N1 at a fixed baud.
//   Sits between the fifo's read side (i_rd/o_data/o_empty) and the board TX pin.
//
// PARAMETERS
//   DATA_SZ   8     bits per character (data bus width of attached fifo)
//   BAUD_DIV  417   clock cycles per bit (48 MHz / 115200); must be >= 2
//
// PORTS
//   i_clk    in   1        system clock
//   i_rst_n  in   1        synchronous reset, active-low
//   i_empty  in   1        fifo empty flag
//   i_data   in   DATA_SZ  fifo head data, valid whenever !i_empty
//   o_rd     out  1        fifo pop strobe, one cycle per character
//   o_tx     out  1        serial line, idle high
//   o_busy   out  1        high while a frame is in progress
//
// BEHAVIOUR
//   - Reset (i_rst_n==0 at posedge): state=IDLE, o_tx=1, o_busy=0, o_rd=0,
//     counters 0. Applies mid-frame: line returns high next edge, char dropped.
//   - o_rd = (state==IDLE || last cycle of STOP) && !i_empty && i_rst_n; comb.
//     Same cycle: i_data latched into shift reg; next cycle state=START.
//   - States: IDLE -> START -> DATA -> STOP -> (IDLE | START).
//     IDLE:  o_tx=1, o_busy=0; leaves on pop.
//     START: o_tx=0 for BAUD_DIV cycles.
//     DATA:  o_tx=shift[0] per bit for BAUD_DIV cycles each; shift right,
//            bit counter 0..DATA_SZ-1; exits after bit DATA_SZ-1.
//     STOP:  o_tx=1 for BAUD_DIV cycles. In its last cycle pop if !i_empty and
//            go to START (back-to-back, no idle gap), else IDLE.
//   - o_busy=1 in START/DATA/STOP. o_tx registered: glitch-free.
//   - Baud counter width $clog2(BAUD_DIV); counts 0..BAUD_DIV-1, wraps to 0
//     on every bit boundary; never free-runs in IDLE (held 0).
//   - Frame length exactly (DATA_SZ+2)*BAUD_DIV cycles; first start-bit cycle
//     is the cycle after the pop.
//   - Never pops while i_empty=1; never pops twice per frame.
//
// CONFIGURATION
//   SERIAL_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP,
//     o_tx = XOR of the DATA_SZ data bits (even parity) for BAUD_DIV cycles;
//     frame = (DATA_SZ+3)*BAUD_DIV cycles.
//   Undefined: no parity state, 8N1 frame as above.
//
// TESTING  (bench uses BAUD_DIV=4)
//   1 reset held 3 cycles, i_empty=1 -> o_tx=1, o_busy=0, o_rd never asserted.
//   2 fifo holds 8'hA5 -> o_rd one cycle; o_tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles
//     (40 cycles), then o_busy=0.
//   3 fifo holds 8'h00,8'hFF -> second o_rd in last STOP cycle of frame 1;
//     start bit of frame 2 follows with no idle cycle; 80 cycles total busy.
//   4 i_rst_n low at cycle 17 of a frame -> o_tx=1, o_busy=0 next edge; no o_rd
//     until i_rst_n high and !i_empty.
//   5 i_empty toggles during DATA -> o_rd stays 0 until STOP end; one pop per frame.
//   6 SERIAL_TX_PARITY_EN, 8'h07 -> parity bit 1 before stop; frame 44 cycles.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: UART transmitter that drains a show-ahead synchronous FIFO read
// port. It pops one character at a time and shifts it out LSB-first as
// 8N1 (or 8E1 when SERIAL_TX_PARITY_EN is defined) at a fixed baud.
//
// Optional feature macro: SERIAL_TX_PARITY_EN
//   defined   : even-parity bit inserted between the data bits and the stop bit
//   undefined : plain start / data / stop frame
//
// Parameters
//   DATA_SZ   bits per character (fifo data width)
//   BAUD_DIV  clock cycles per bit, must be >= 2
//
// Ports
//   i_clk    system clock
//   i_rst_n  synchronous reset, active-low
//   i_empty  fifo empty flag
//   i_data   fifo head data, valid whenever !i_empty
//   o_rd     fifo pop strobe, one cycle per character (combinational)
//   o_tx     serial line, idle high, registered
//   o_busy   high while a frame is in progress
module serial_tx #(
  parameter int DATA_SZ  = 8,
  parameter int BAUD_DIV = 417
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_empty,
  input  logic [DATA_SZ-1:0] i_data,
  output logic               o_rd,
  output logic               o_tx,
  output logic               o_busy
);

  localparam int BW   = $clog2(BAUD_DIV);
  localparam int BITW = (DATA_SZ > 1) ? $clog2(DATA_SZ) : 1;

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             r_state, w_state_next;
  logic [BW-1:0]      r_baud, w_baud_next;
  logic [BITW-1:0]    r_bit, w_bit_next;
  logic [DATA_SZ-1:0] r_shift, w_shift_next, w_shift_shr;
  logic               r_tx, w_tx_next;
  logic               w_baud_last, w_bit_last, w_pop;
`ifdef SERIAL_TX_PARITY_EN
  logic               r_par, w_par_next;
`endif

  assign w_shift_shr = r_shift >> 1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= w_par_next;
`endif
    end
  end

  // o_tx is a register, so each transition loads the line level of the
  // state/bit being entered rather than the one being left.
  always_comb begin
    w_baud_last  = (r_baud == BW'(BAUD_DIV - 1));
    w_bit_last   = (r_bit == BITW'(DATA_SZ - 1));
    w_pop        = ((r_state == S_IDLE) || (r_state == S_STOP && w_baud_last))
                   && !i_empty && i_rst_n;
    w_state_next = r_state;
    w_baud_next  = w_baud_last ? '0 : r_baud + 1'b1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
`ifdef SERIAL_TX_PARITY_EN
    w_par_next   = r_par;
`endif

    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (w_pop) begin
          w_state_next = S_START;
          w_shift_next = i_data;
          w_bit_next   = '0;
          w_tx_next    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          w_par_next   = ^i_data;
`endif
        end
      end

      S_START: begin
        if (w_baud_last) begin
          w_state_next = S_DATA;
          w_bit_next   = '0;
          w_tx_next    = r_shift[0];
        end
      end

      S_DATA: begin
        if (w_baud_last) begin
          if (w_bit_last) begin
`ifdef SERIAL_TX_PARITY_EN
            w_state_next = S_PARITY;
            w_tx_next    = r_par;
`else
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_next   = r_bit + 1'b1;
            w_shift_next = w_shift_shr;
            w_tx_next    = w_shift_shr[0];
          end
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) begin
          w_state_next = S_STOP;
          w_tx_next    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (w_baud_last) begin
          if (w_pop) begin
            // back-to-back: next start bit immediately, no idle cycle
            w_state_next = S_START;
            w_shift_next = i_data;
            w_bit_next   = '0;
            w_tx_next    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            w_par_next   = ^i_data;
`endif
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign o_rd   = w_pop;
  assign o_tx   = r_tx;
  assign o_busy = (r_state != S_IDLE);

endmodule
